issue_scoreboard: RTL and testbench

- In-order issue check between the instruction queue and register read.
- Examines the queue head each cycle and tracks in-flight destination registers, using per-register busy bits and fixed-latency countdown counters.
- Asserts issue_o, wired to the queue's read_head_i, only when there is no RAW, WAW or divider structural hazard and the backend is ready.
- Variable-latency producers (DIV, MEM) are cleared by the writeback port.

---
 rtl/issue_scoreboard.sv | 175 +++++++++++++++++
 tb/tb_issue_scoreboard.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-register busy/countdown tracking with RAW, WAW and
// divider structural hazard detection for the instruction-queue head.
module issue_scoreboard #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ALU_LAT  = 1,
   parameter int unsigned MUL_LAT  = 2,
   parameter int unsigned CNT_W    = 2
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                head_valid_i,
   input  logic [4:0]          rs1_i,
   input  logic [4:0]          rs2_i,
   input  logic                use_rs1_i,
   input  logic                use_rs2_i,
   input  logic [4:0]          rd_i,
   input  logic                regwrite_i,
   input  logic [1:0]          unit_i,
   input  logic                exe_ready_i,
   input  logic                wb_valid_i,
   input  logic [4:0]          wb_rd_i,
   input  logic                div_done_i,
   input  logic                flush_i,
   output logic                issue_o,
   output logic [2:0]          stall_cause_o,
   output logic [NUM_REGS-1:0] busy_o
);

   localparam logic [1:0]       UNIT_ALU = 2'd0;
   localparam logic [1:0]       UNIT_MUL = 2'd1;
   localparam logic [1:0]       UNIT_DIV = 2'd2;
   localparam logic [1:0]       UNIT_MEM = 2'd3;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
   localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [NUM_REGS-1:0] fixed_q, fixed_d;
   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic                div_busy_q, div_busy_d;

   logic [NUM_REGS-1:0] avail_s;
   logic                raw_s, waw_s, struct_s, issue_s, alloc_s;
   logic [2:0]          stall_s;

   // Register availability; a countdown at 1 or a same-cycle writeback is bypassable.
   always_comb begin
      avail_s = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (r == 0) begin
            avail_s[r] = 1'b1;
         end else begin
            avail_s[r] = ~busy_q[r]
                       | (fixed_q[r] & (cnt_q[r] == CNT_ONE))
                       | (wb_valid_i & (wb_rd_i == 5'(r)));
         end
      end
   end

   // Hazard evaluation, issue decision and stall reason for the queue head.
   always_comb begin
      raw_s    = (use_rs1_i & ~avail_s[rs1_i]) | (use_rs2_i & ~avail_s[rs2_i]);
      waw_s    = regwrite_i & (rd_i != 5'd0) & ~avail_s[rd_i];
      struct_s = (unit_i == UNIT_DIV) & div_busy_q & ~div_done_i;
      issue_s  = rstn_i & head_valid_i & ~flush_i & exe_ready_i & ~raw_s & ~waw_s & ~struct_s;
      alloc_s  = issue_s & regwrite_i & (rd_i != 5'd0);
      if (rstn_i & head_valid_i & ~flush_i & ~issue_s) begin
         stall_s = {struct_s, waw_s, raw_s};
      end else begin
         stall_s = 3'b000;
      end
   end

   // Next-state: flush wins, then decrement, writeback, new producer, divider.
   always_comb begin
      busy_d     = busy_q;
      fixed_d    = fixed_q;
      cnt_d      = cnt_q;
      div_busy_d = div_busy_q;
      if (flush_i) begin
         busy_d     = '0;
         fixed_d    = '0;
         div_busy_d = 1'b0;
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = CNT_ZERO;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (fixed_q[r] && (cnt_q[r] != CNT_ZERO)) begin
               cnt_d[r] = cnt_q[r] - CNT_ONE;
               if (cnt_q[r] == CNT_ONE) begin
                  busy_d[r]  = 1'b0;
                  fixed_d[r] = 1'b0;
               end else begin
                  busy_d[r]  = busy_q[r];
                  fixed_d[r] = fixed_q[r];
               end
            end else begin
               cnt_d[r] = cnt_q[r];
            end
         end

         // A writeback landing on a fixed-latency entry is illegal but still clears it.
         if (wb_valid_i && (wb_rd_i != 5'd0)) begin
            busy_d[wb_rd_i]  = 1'b0;
            fixed_d[wb_rd_i] = 1'b0;
            cnt_d[wb_rd_i]   = CNT_ZERO;
         end else begin
            busy_d[0] = 1'b0;
         end

         if (alloc_s) begin
            busy_d[rd_i] = 1'b1;
            case (unit_i)
               UNIT_ALU: begin
                  fixed_d[rd_i] = 1'b1;
                  cnt_d[rd_i]   = ALU_CNT;
               end
               UNIT_MUL: begin
                  fixed_d[rd_i] = 1'b1;
                  cnt_d[rd_i]   = MUL_CNT;
               end
               UNIT_DIV, UNIT_MEM: begin
                  fixed_d[rd_i] = 1'b0;
                  cnt_d[rd_i]   = CNT_ZERO;
               end
               default: begin
                  fixed_d[rd_i] = 1'b0;
                  cnt_d[rd_i]   = CNT_ZERO;
               end
            endcase
         end else begin
            busy_d[0] = 1'b0;
         end

         if (issue_s && (unit_i == UNIT_DIV)) begin
            div_busy_d = 1'b1;
         end else if (div_done_i) begin
            div_busy_d = 1'b0;
         end else begin
            div_busy_d = div_busy_q;
         end

         busy_d[0]  = 1'b0;
         fixed_d[0] = 1'b0;
         cnt_d[0]   = CNT_ZERO;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         busy_q     <= '0;
         fixed_q    <= '0;
         div_busy_q <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= CNT_ZERO;
         end
      end else begin
         busy_q     <= busy_d;
         fixed_q    <= fixed_d;
         div_busy_q <= div_busy_d;
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   assign issue_o       = issue_s;
   assign stall_cause_o = stall_s;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized bench for issue_scoreboard against a timestamp-based reference model.
module tb_issue_scoreboard;

   localparam int ALU_LAT = 1;
   localparam int MUL_LAT = 2;

   logic        clk_i = 1'b0;
   logic        rstn_i, head_valid_i, use_rs1_i, use_rs2_i, regwrite_i;
   logic        exe_ready_i, wb_valid_i, div_done_i, flush_i;
   logic [4:0]  rs1_i, rs2_i, rd_i, wb_rd_i;
   logic [1:0]  unit_i;
   logic        issue_o;
   logic [2:0]  stall_cause_o;
   logic [31:0] busy_o;

   always #5 clk_i = ~clk_i;

   issue_scoreboard #(.NUM_REGS(32), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT), .CNT_W(2)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .head_valid_i(head_valid_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
      .rd_i(rd_i), .regwrite_i(regwrite_i), .unit_i(unit_i), .exe_ready_i(exe_ready_i),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .div_done_i(div_done_i),
      .flush_i(flush_i), .issue_o(issue_o), .stall_cause_o(stall_cause_o), .busy_o(busy_o)
   );

   // Model: a register is either free, a fixed producer ready at an absolute cycle,
   // or a variable producer waiting for its writeback.
   typedef enum int {K_NONE, K_FIXED, K_VAR} kind_e;
   kind_e m_kind  [32];
   int    m_until [32];
   bit    m_div_busy;
   int    cyc;
   int    n_vec = 0;
   int    n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit m_busy(input int r);
      if (r == 0) return 1'b0;
      if (m_kind[r] == K_FIXED) return cyc <= m_until[r];
      return m_kind[r] == K_VAR;
   endfunction

   function automatic bit m_avail(input int r);
      return (r == 0) || !m_busy(r) ||
             (m_kind[r] == K_FIXED && cyc == m_until[r]) ||
             (wb_valid_i && int'(wb_rd_i) == r);
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 32; r++) begin
         m_kind[r]  = K_NONE;
         m_until[r] = 0;
      end
      m_div_busy = 1'b0;
   endtask

   task automatic set_idle();
      head_valid_i = 1'b0; rs1_i = 5'd0; rs2_i = 5'd0; use_rs1_i = 1'b0; use_rs2_i = 1'b0;
      rd_i = 5'd0; regwrite_i = 1'b0; unit_i = 2'd0; exe_ready_i = 1'b1;
      wb_valid_i = 1'b0; wb_rd_i = 5'd0; div_done_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic set_head(input logic [4:0] rd, input logic rw, input logic [1:0] unit,
                           input logic [4:0] s1, input logic u1,
                           input logic [4:0] s2, input logic u2);
      head_valid_i = 1'b1; rd_i = rd; regwrite_i = rw; unit_i = unit;
      rs1_i = s1; use_rs1_i = u1; rs2_i = s2; use_rs2_i = u2;
   endtask

   // Compare one cycle, then advance the model across the clock edge.
   task automatic step();
      bit raw, waw, st, iss;
      logic [2:0]  stall;
      logic [31:0] bv;
      #1;
      raw   = (use_rs1_i && !m_avail(int'(rs1_i))) || (use_rs2_i && !m_avail(int'(rs2_i)));
      waw   = regwrite_i && rd_i != 5'd0 && !m_avail(int'(rd_i));
      st    = (unit_i == 2'd2) && m_div_busy && !div_done_i;
      iss   = rstn_i && head_valid_i && !flush_i && exe_ready_i && !raw && !waw && !st;
      stall = (rstn_i && head_valid_i && !flush_i && !iss) ? {st, waw, raw} : 3'b000;
      for (int r = 0; r < 32; r++) bv[r] = m_busy(r);
      check_val("issue", {31'd0, issue_o}, {31'd0, iss});
      check_val("stall_cause", {29'd0, stall_cause_o}, {29'd0, stall});
      check_val("busy", busy_o, bv);
      @(posedge clk_i);
      if (!rstn_i || flush_i) begin
         model_clear();
      end else begin
         if (wb_valid_i && wb_rd_i != 5'd0) m_kind[wb_rd_i] = K_NONE;
         if (iss && regwrite_i && rd_i != 5'd0) begin
            if (unit_i == 2'd0) begin
               m_kind[rd_i] = K_FIXED; m_until[rd_i] = cyc + ALU_LAT;
            end else if (unit_i == 2'd1) begin
               m_kind[rd_i] = K_FIXED; m_until[rd_i] = cyc + MUL_LAT;
            end else begin
               m_kind[rd_i] = K_VAR;
            end
         end
         if (iss && unit_i == 2'd2) m_div_busy = 1'b1;
         else if (div_done_i) m_div_busy = 1'b0;
      end
      cyc++;
      @(negedge clk_i);
   endtask

   initial begin
      cyc = 0;
      model_clear();
      set_idle();
      rstn_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      // Outputs must stay low under reset even with an issuable head.
      set_head(5'd5, 1'b1, 2'd0, 5'd1, 1'b1, 5'd2, 1'b1);
      step();
      rstn_i = 1'b1;

      // ALU producer then immediate dependent.
      set_head(5'd5, 1'b1, 2'd0, 5'd1, 1'b1, 5'd2, 1'b0); step();
      set_head(5'd6, 1'b1, 2'd0, 5'd5, 1'b1, 5'd5, 1'b1); step();
      set_idle(); step(); step();

      // MUL producer: dependent stalls one cycle.
      set_head(5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0); step();
      set_head(5'd8, 1'b1, 2'd0, 5'd7, 1'b1, 5'd0, 1'b0); step(); step();
      set_idle(); step(); step();

      // MEM load with late writeback releasing the consumer.
      set_head(5'd9, 1'b1, 2'd3, 5'd0, 1'b0, 5'd0, 1'b0); step();
      set_head(5'd10, 1'b1, 2'd0, 5'd9, 1'b1, 5'd0, 1'b0);
      repeat (4) step();
      wb_valid_i = 1'b1; wb_rd_i = 5'd9; step();
      set_idle(); step(); step();

      // WAW against an in-flight load, then a back-to-back DIV structural stall.
      set_head(5'd3, 1'b1, 2'd3, 5'd0, 1'b0, 5'd0, 1'b0); step();
      set_head(5'd3, 1'b1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0); step(); step();
      wb_valid_i = 1'b1; wb_rd_i = 5'd3; step();
      set_idle(); step();
      set_head(5'd12, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0); step();
      set_head(5'd13, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0);
      repeat (6) step();
      div_done_i = 1'b1; step();
      div_done_i = 1'b0; set_idle(); step();

      // Flush with state in flight, then a DIV right after.
      set_head(5'd7, 1'b1, 2'd3, 5'd0, 1'b0, 5'd0, 1'b0); step();
      set_head(5'd9, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0); step();
      flush_i = 1'b1; step();
      flush_i = 1'b0; set_head(5'd4, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0); step();
      set_idle(); step();

      for (int i = 0; i < 3000; i++) begin
         rstn_i       = ($urandom_range(0, 99) != 0);
         flush_i      = ($urandom_range(0, 39) == 0);
         head_valid_i = ($urandom_range(0, 7) != 0);
         rs1_i        = 5'($urandom_range(0, 7));
         rs2_i        = 5'($urandom_range(0, 7));
         use_rs1_i    = 1'($urandom_range(0, 1));
         use_rs2_i    = 1'($urandom_range(0, 1));
         rd_i         = 5'($urandom_range(0, 7));
         regwrite_i   = ($urandom_range(0, 3) != 0);
         unit_i       = 2'($urandom_range(0, 3));
         exe_ready_i  = ($urandom_range(0, 3) != 0);
         wb_valid_i   = ($urandom_range(0, 2) == 0);
         wb_rd_i      = 5'($urandom_range(0, 7));
         div_done_i   = ($urandom_range(0, 5) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
